// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    // Width of a down-counter that must hold the value n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mul_aq_reg.sv
// Accumulator datapath {A,Q} plus multiplicand M: loads operands and performs one add/shift per step.
// BOOTH_SIGNED_EN selects two's complement Booth radix-2 steps instead of unsigned shift-add.
module mul_aq_reg
    import mul_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic             step,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic [2*N-1:0]   product
);

    logic [N-1:0] m_q;
    logic [N-1:0] a_q;
    logic [N-1:0] q_q;

`ifdef BOOTH_SIGNED_EN
    logic         q1_q;
    logic [N:0]   a_ext;
    logic [N:0]   m_ext;
    logic [N:0]   r;

    // Booth decode on {Q[0],q_1}; the N+1 bit result keeps the true sign for the arithmetic shift.
    always_comb begin
        a_ext = {a_q[N-1], a_q};
        m_ext = {m_q[N-1], m_q};
        r     = a_ext;
        case ({q_q[0], q1_q})
            2'b01:   r = a_ext + m_ext;
            2'b10:   r = a_ext - m_ext;
            default: r = a_ext;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_q  <= '0;
            a_q  <= '0;
            q_q  <= '0;
            q1_q <= 1'b0;
        end else if (load) begin
            m_q  <= multiplicand;
            q_q  <= multiplier;
            a_q  <= '0;
            q1_q <= 1'b0;
        end else if (step) begin
            {a_q, q_q, q1_q} <= {r[N], r[N-1:0], q_q};
        end
    end
`else
    logic [N:0] s;

    // Carry lands in s[N] and is shifted straight into A, so no separate C flop is kept.
    always_comb begin
        s = {1'b0, a_q};
        if (q_q[0]) begin
            s = {1'b0, a_q} + {1'b0, m_q};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_q <= '0;
            a_q <= '0;
            q_q <= '0;
        end else if (load) begin
            m_q <= multiplicand;
            q_q <= multiplier;
            a_q <= '0;
        end else if (step) begin
            {a_q, q_q} <= {s, q_q[N-1:1]};
        end
    end
`endif

    assign product = {a_q, q_q};

endmodule

// File: rtl/seq_shift_add_mul.sv
// Iterative N-bit multiplier with valid/ready handshakes; one add/shift step per clock.
// Build with BOOTH_SIGNED_EN for two's complement operands and product.
module seq_shift_add_mul
    import mul_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     multiplicand,
    input  logic [N-1:0]     multiplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product
);

    localparam int unsigned CW = cnt_w(N);

    mul_state_t    state;
    mul_state_t    state_next;
    logic [CW-1:0] count;
    logic          load;
    logic          step;

    // State register; handshake flags are registered from the next state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= '0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
            if (load) begin
                count <= CW'(N);
            end else if (step) begin
                count <= count - CW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mul_aq_reg #(.N(N)) u_aq (
        .clock        (clock),
        .resetn       (resetn),
        .load         (load),
        .step         (step),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product)
    );

endmodule
